muladd_dot_seq: RTL and testbench

- Upstream sequencer for the MULADD DSP BEL running in accumulate mode (A_reg=0, B_reg=0, C_reg=0, ACC=1, signExtension=0, ACCout=0).
- Accepts a valid/ready stream of 8-bit operand pairs with a last marker and drives one term per cycle into MULADD A/B.
- Pulses MULADD clr at the end of each vector, captures the combinational Q, and presents the dot-product result on a valid/ready output with a term count and an overflow flag.

---
 rtl/muladd_pkg.sv | 18 +
 rtl/muladd_dot_seq.sv | 135 +++++++++++++
 tb/tb_muladd_dot_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muladd_pkg.sv
// Shared types and constants for the MULADD dot-product sequencer.
package muladd_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 20;

  // MULADD ConfigBits: unregistered A/B/C, accumulate on, unsigned, ACC not on output
  localparam logic [5:0] MULADD_CFG_ACCUM = 6'b001000;

endpackage

// File: rtl/muladd_dot_seq.sv
// Streams operand pairs into a MULADD running in accumulate mode, clears its
// accumulator at the end of each vector and returns the dot product.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_INIT  | one cycle after reset, MULADD clr still asserted
//   ST_ACCUM | accepting beats, one product fed to MULADD per cycle
//   ST_FLUSH | last product is in mul_q; capture it while ACC clears
//   ST_HOLD  | result presented until the consumer takes it
module muladd_dot_seq
  import muladd_pkg::*;
#(
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 6
) (
  input  logic               UserCLK,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [A_W-1:0]     s_a,
  input  logic [B_W-1:0]     s_b,
  input  logic               s_last,
  output logic [A_W-1:0]     mul_a,
  output logic [B_W-1:0]     mul_b,
  output logic [ACC_W-1:0]   mul_c,
  output logic               mul_clr,
  input  logic [ACC_W-1:0]   mul_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_ovf
);

  localparam logic [CNT_W-1:0] MAX_TERMS_C = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [A_W-1:0]     mul_a_q, mul_a_d;
  logic [B_W-1:0]     mul_b_q, mul_b_d;
  logic               mul_clr_q, mul_clr_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign s_ready   = (state_q == ST_ACCUM);
  assign accept    = s_valid && s_ready;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_c     = '0;
  assign mul_clr   = mul_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;

  // State register
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_ACCUM;
      ST_ACCUM: if (accept && s_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_HOLD;
      ST_HOLD:  if (res_valid_q && res_ready) state_d = ST_ACCUM;
      default:  state_d = ST_INIT;
    endcase
  end

  // Output/datapath next values; operands default to zero so ACC holds when idle
  always_comb begin
    mul_a_d     = '0;
    mul_b_d     = '0;
    mul_clr_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          mul_a_d   = s_a;
          mul_b_d   = s_b;
          mul_clr_d = s_last;
          cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // mul_q already holds ACC plus the last product; ACC clears on this edge
        res_data_d  = mul_q;
        res_count_d = cnt_q;
        res_ovf_d   = (cnt_q > MAX_TERMS_C);
        res_valid_d = 1'b1;
        cnt_d       = '0;
      end
      ST_HOLD: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; mul_clr resets high so MULADD ACC clears during reset
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_clr_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_clr_q   <= mul_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muladd_dot_seq.sv
// Directed bench for muladd_dot_seq with a behavioural MULADD in accumulate mode.
module tb_muladd_dot_seq;

  logic        UserCLK = 1'b0;
  logic        rst     = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_a     = '0;
  logic [7:0]  s_b     = '0;
  logic        s_last  = 1'b0;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [19:0] mul_c;
  logic        mul_clr;
  logic [19:0] mul_q;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [19:0] res_data;
  logic [5:0]  res_count;
  logic        res_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // MULADD model: combinational Q = A*B + ACC, ACC has no reset, clr is synchronous
  logic [19:0] acc_q = 20'h12345;
  logic [19:0] prod;
  assign prod  = {12'b0, mul_a} * {12'b0, mul_b};
  assign mul_q = prod + acc_q;
  always @(posedge UserCLK) acc_q <= mul_clr ? 20'd0 : mul_q;

  always #5 UserCLK = ~UserCLK;

  muladd_dot_seq #(.MAX_TERMS(16), .CNT_W(6)) dut (
    .UserCLK   (UserCLK),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_last    (s_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_clr   (mul_clr),
    .mul_q     (mul_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .res_ovf   (res_ovf)
  );

  // Present one beat and return #1 after the edge that accepts it
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok = 0;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge UserCLK);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: s_ready never high for beat a=%0d b=%0d", a, b);
    end
    @(posedge UserCLK); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Wait (bounded) until res_valid is seen #1 after an edge
  task automatic wait_result();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin ok = 1; break; end
      @(posedge UserCLK); #1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL result_timeout: res_valid never asserted");
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge UserCLK); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge UserCLK);
    #1;
    n_checks++; if (mul_clr !== 1'b1) $display("FAIL rst_mul_clr: got %0b expected 1", mul_clr); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %0b expected 0", s_ready); else n_pass++;
    n_checks++; if ({res_valid, res_data, res_count, res_ovf} !== 28'd0)
      $display("FAIL rst_res: got valid=%0b data=%0d count=%0d ovf=%0b expected all 0", res_valid, res_data, res_count, res_ovf);
    else n_pass++;
    n_checks++; if ({mul_a, mul_b, mul_c} !== 36'd0)
      $display("FAIL rst_mul_ops: got a=%0d b=%0d c=%0d expected 0", mul_a, mul_b, mul_c);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (mul_clr !== 1'b1 || s_ready !== 1'b0)
      $display("FAIL init_cycle: got clr=%0b s_ready=%0b expected clr=1 s_ready=0", mul_clr, s_ready);
    else n_pass++;
    @(posedge UserCLK); #1;
    n_checks++; if (mul_clr !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL accum_entry: got clr=%0b s_ready=%0b expected clr=0 s_ready=1", mul_clr, s_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b1);
    n_checks++; if (res_valid !== 1'b0 || mul_clr !== 1'b1 || mul_a !== 8'd5)
      $display("FAIL basic_flush: got valid=%0b clr=%0b mul_a=%0d expected 0 1 5", res_valid, mul_clr, mul_a);
    else n_pass++;
    @(posedge UserCLK); #1;
    n_checks++; if (res_valid !== 1'b1) $display("FAIL basic_latency: got res_valid=%0b expected 1", res_valid); else n_pass++;
    n_checks++; if (res_data !== 20'd42 || res_count !== 6'd2 || res_ovf !== 1'b0)
      $display("FAIL basic_result: got data=%0d count=%0d ovf=%0b expected 42 2 0", res_data, res_count, res_ovf);
    else n_pass++;
    handshake();
    n_checks++; if (res_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL basic_handshake: got valid=%0b s_ready=%0b expected 0 1", res_valid, s_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    send(8'd255, 8'd255, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd65025 || res_count !== 6'd1 || res_ovf !== 1'b0)
      $display("FAIL single_max: got data=%0d count=%0d ovf=%0b expected 65025 1 0", res_data, res_count, res_ovf);
    else n_pass++;
    handshake();
    send(8'd1, 8'd1, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd1 || res_count !== 6'd1)
      $display("FAIL single_after_clear: got data=%0d count=%0d expected 1 1", res_data, res_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_max_terms();
    for (int i = 0; i < 16; i++) send(8'd255, 8'd255, (i == 15));
    wait_result();
    n_checks++; if (res_data !== 20'd1040400 || res_count !== 6'd16 || res_ovf !== 1'b0)
      $display("FAIL terms16: got data=%0d count=%0d ovf=%0b expected 1040400 16 0", res_data, res_count, res_ovf);
    else n_pass++;
    handshake();
    for (int i = 0; i < 17; i++) send(8'd255, 8'd255, (i == 16));
    wait_result();
    // 17*65025 = 1105425, minus 2^20 = 56849
    n_checks++; if (res_data !== 20'd56849 || res_count !== 6'd17 || res_ovf !== 1'b1)
      $display("FAIL terms17: got data=%0d count=%0d ovf=%0b expected 56849 17 1", res_data, res_count, res_ovf);
    else n_pass++;
    handshake();
  endtask

  task automatic test_backpressure();
    send(8'd2, 8'd3, 1'b1);
    wait_result();
    s_a = 8'd7; s_b = 8'd7; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge UserCLK); #1;
      n_checks++; if (s_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 20'd6 ||
                      res_count !== 6'd1 || res_ovf !== 1'b0 || mul_a !== 8'd0)
        $display("FAIL hold_stable: cycle %0d got s_ready=%0b valid=%0b data=%0d count=%0d mul_a=%0d expected 0 1 6 1 0",
                 i, s_ready, res_valid, res_data, res_count, mul_a);
      else n_pass++;
    end
    handshake();
    n_checks++; if (mul_a !== 8'd0 || s_ready !== 1'b1)
      $display("FAIL hold_release: got mul_a=%0d s_ready=%0b expected 0 1", mul_a, s_ready);
    else n_pass++;
    send(8'd7, 8'd7, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd49 || res_count !== 6'd1)
      $display("FAIL hold_next_vec: got data=%0d count=%0d expected 49 1", res_data, res_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_gaps();
    send(8'd2, 8'd2, 1'b0);
    @(posedge UserCLK); #1;
    n_checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0)
      $display("FAIL gap_idle_ops: got a=%0d b=%0d expected 0 0", mul_a, mul_b);
    else n_pass++;
    @(posedge UserCLK); #1;
    send(8'd3, 8'd3, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd13 || res_count !== 6'd2)
      $display("FAIL gap_result: got data=%0d count=%0d expected 13 2", res_data, res_count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_zero_terms();
    send(8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd5, 1'b0);
    send(8'd4, 8'd0, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd0 || res_count !== 6'd3 || res_ovf !== 1'b0)
      $display("FAIL zero_terms: got data=%0d count=%0d ovf=%0b expected 0 3 0", res_data, res_count, res_ovf);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid();
    send(8'd10, 8'd10, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++; if (mul_clr !== 1'b1 || res_valid !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL midrst_async: got clr=%0b valid=%0b s_ready=%0b expected 1 0 0", mul_clr, res_valid, s_ready);
    else n_pass++;
    repeat (2) @(posedge UserCLK);
    #1;
    rst = 1'b0;
    @(posedge UserCLK); #1;
    n_checks++; if (res_valid !== 1'b0)
      $display("FAIL midrst_no_stale: got res_valid=%0b expected 0", res_valid);
    else n_pass++;
    send(8'd1, 8'd2, 1'b1);
    wait_result();
    n_checks++; if (res_data !== 20'd2 || res_count !== 6'd1)
      $display("FAIL midrst_result: got data=%0d count=%0d expected 2 1", res_data, res_count);
    else n_pass++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_max_terms();
    test_backpressure();
    test_gaps();
    test_zero_terms();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
